// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular FIFO with one enqueue and up to DEQ_W
// in-order dequeues per cycle, presented as a window starting at head.
module fetch_buffer #(
  parameter int IDX_W  = 3,
  parameter int DEQ_W  = 2,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  localparam int DEPTH = 2 ** IDX_W,
  localparam int CNT_W = $clog2(DEQ_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [DATA_W-1:0]       enq_instr,
  input  logic [PC_W-1:0]         enq_pc,
  output logic [DEQ_W-1:0]        deq_valid,
  output logic [DEQ_W*DATA_W-1:0] deq_instr,
  output logic [DEQ_W*PC_W-1:0]   deq_pc,
  input  logic [CNT_W-1:0]        deq_count,
  output logic [IDX_W:0]          count,
  output logic                    empty,
  output logic                    full,
  output logic                    deq_err
);

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]   pc_q    [DEPTH];

  logic [IDX_W:0] head_q, head_d;
  logic [IDX_W:0] tail_q, tail_d;
  logic           err_q, err_d;

  logic [IDX_W:0] deq_ext;
  logic [IDX_W:0] deq_eff;
  logic           acc;

  // Wrap bits make tail - head the exact occupancy, 0..DEPTH.
  assign count     = tail_q - head_q;
  assign empty     = (count == '0);
  assign full      = (count == (IDX_W+1)'(DEPTH));
  assign enq_ready = !full;
  assign deq_err   = err_q;

  assign deq_ext = (IDX_W+1)'(deq_count);
  assign deq_eff = (deq_ext > count) ? count : deq_ext;
  assign acc     = enq_valid && !full && !flush && !rst;

  for (genvar i = 0; i < DEQ_W; i++) begin : g_slot
    logic [IDX_W-1:0] idx;
    assign idx = head_q[IDX_W-1:0] + IDX_W'(i);
    assign deq_valid[i] = (count > (IDX_W+1)'(i));
    assign deq_instr[i*DATA_W +: DATA_W] = instr_q[idx];
    assign deq_pc[i*PC_W +: PC_W] = pc_q[idx];
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    err_d  = err_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      err_d  = 1'b0;
    end else begin
      head_d = head_q + deq_eff;
      if (acc)
        tail_d = tail_q + 1'b1;
      if (deq_ext > count)
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      instr_q[tail_q[IDX_W-1:0]] <= enq_instr;
      pc_q[tail_q[IDX_W-1:0]]    <= enq_pc;
    end
  end

endmodule
